// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and constants for the serial loopback feeder
// Contents:
//   state_e        frame sequencer states
//   WIDTH_DEFAULT  frame width, equal to the downstream shift-register depth
//   SEL_W_DEFAULT  readback select width, log2(WIDTH_DEFAULT)
//   ERR_CNT_MAX    saturation value of the mismatch counter

package ser_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int SEL_W_DEFAULT = 3;
  localparam int ERR_CNT_MAX   = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/ser_bit_cnt.sv
// rtl/ser_bit_cnt.sv - bit-index counter shared by the shift and readback phases
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load_i      restart the index at 0 (wins over step_i)
//   step_i      advance the index by one
//   cnt_o       current bit index
//   tc_o        index is at the last bit of the frame

module ser_bit_cnt
  import ser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SEL_W = SEL_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  output logic [SEL_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(WIDTH - 1);

  logic [SEL_W-1:0] cnt_q;
  logic [SEL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST_IDX);

endmodule

// File: rtl/serial_loopback_feeder.sv
// rtl/serial_loopback_feeder.sv - serializes a frame into an external shifter and verifies it by readback
// Build option: SERIAL_LOOPBACK_LSB_FIRST_EN sends in_data[0] first and mirrors the readback index;
// latency is identical in both builds.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid, in_data, in_ready  frame handshake (accepted only in IDLE)
//   S, enable                  serial bit and shift enable to the downstream register
//   A, B, C                    readback select, {A,B,C} is the bit index with A as MSB
//   Z                          downstream bit selected by {A,B,C}
//   done                       one-cycle end-of-frame pulse
//   match                      last frame read back intact, held until the next done
//   err_cnt                    saturating count of mismatched frames

module serial_loopback_feeder
  import ser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SEL_W = SEL_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             S,
  output logic             enable,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             Z,
  output logic             done,
  output logic             match,
  output logic [7:0]       err_cnt
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(WIDTH - 1);

  // Bit sent on shift step j. After WIDTH shifts the downstream register
  // holds in_data at the matching positions (MSB-first build) or mirrored.
  function automatic logic tx_bit(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] j);
`ifdef SERIAL_LOOPBACK_LSB_FIRST_EN
    return d[j];
`else
    return d[LAST_IDX - j];
`endif
  endfunction

  // Latched bit that downstream position i must hold after the shift phase.
  function automatic logic chk_bit(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] i);
`ifdef SERIAL_LOOPBACK_LSB_FIRST_EN
    return d[LAST_IDX - i];
`else
    return d[i];
`endif
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             s_q,     s_d;
  logic             en_q,    en_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic             rdy_q,   rdy_d;
  logic             done_q,  done_d;
  logic             match_q, match_d;
  logic             ok_q,    ok_d;
  logic [7:0]       err_q,   err_d;

  logic             cnt_load;
  logic             cnt_step;
  logic [SEL_W-1:0] cnt;
  logic             cnt_tc;
  logic             cmp_ok;

  ser_bit_cnt #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_bit_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .step_i (cnt_step),
    .cnt_o  (cnt),
    .tc_o   (cnt_tc)
  );

  // In CHECK the counter equals the select currently driven on {A,B,C},
  // so Z at this edge belongs to index cnt.
  assign cmp_ok = (Z == chk_bit(data_q, cnt));

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    s_d      = 1'b0;
    en_d     = 1'b0;
    sel_d    = '0;
    rdy_d    = 1'b0;
    done_d   = 1'b0;
    match_d  = match_q;
    ok_d     = ok_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_step = 1'b0;

    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (in_valid && rdy_q) begin
          data_d   = in_data;
          cnt_load = 1'b1;
          s_d      = tx_bit(in_data, '0);
          en_d     = 1'b1;
          rdy_d    = 1'b0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_tc) begin
          // Last bit was captured downstream on this edge; freeze it and
          // start reading back from index 0.
          cnt_load = 1'b1;
          ok_d     = 1'b1;
          state_d  = CHECK;
        end else begin
          cnt_step = 1'b1;
          en_d     = 1'b1;
          s_d      = tx_bit(data_q, cnt + 1'b1);
        end
      end

      CHECK: begin
        if (cnt_tc) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          done_d  = 1'b1;
          match_d = ok_q && cmp_ok;
          if (!(ok_q && cmp_ok) && (err_q != 8'(ERR_CNT_MAX))) begin
            err_d = err_q + 8'd1;
          end
        end else begin
          cnt_step = 1'b1;
          sel_d    = cnt + 1'b1;
          ok_d     = ok_q && cmp_ok;
        end
      end

      default: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      s_q     <= 1'b0;
      en_q    <= 1'b0;
      sel_q   <= '0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      s_q     <= s_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      match_q <= match_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign in_ready = rdy_q;
  assign S        = s_q;
  assign enable   = en_q;
  assign A        = sel_q[2];
  assign B        = sel_q[1];
  assign C        = sel_q[0];
  assign done     = done_q;
  assign match    = match_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_serial_loopback_feeder.sv
// tb/tb_serial_loopback_feeder.sv - self-checking bench for serial_loopback_feeder

module tb_serial_loopback_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, s, enable, a, b, c, z, done, match;
  logic [7:0] err_cnt;

  logic [7:0] q_ds = 8'h00;
  logic [7:0] flip_mask = 8'h00;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  serial_loopback_feeder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .S        (s),
    .enable   (enable),
    .A        (a),
    .B        (b),
    .C        (c),
    .Z        (z),
    .done     (done),
    .match    (match),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream shift register with optional readback corruption.
  always @(posedge clk) if (enable) q_ds <= {q_ds[6:0], s};
  assign z = q_ds[{a, b, c}] ^ flip_mask[{a, b, c}];

  // Reference model: each accepted frame follows a fixed 17-cycle timeline.
  bit         m_active = 1'b0;
  bit         m_busy = 1'b0;
  int         m_d = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_match = 1'b0;
  logic [7:0] m_err = 8'h00;
  logic       m_done = 1'b0;

  function automatic logic tx_order(input logic [7:0] d, input int j);
    logic [2:0] jj;
    jj = 3'(j);
`ifdef SERIAL_LOOPBACK_LSB_FIRST_EN
    return d[jj];
`else
    return d[3'd7 - jj];
`endif
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0;
        m_d      = 0;
        m_match  = 1'b0;
        m_err    = 8'h00;
        m_done   = 1'b0;
      end else begin
        m_busy = m_active;
        m_done = 1'b0;
        if (m_active) begin
          m_d = m_d + 1;
          if (m_d == 16) begin
            m_done   = 1'b1;
            m_active = 1'b0;
            if (flip_mask == 8'h00) begin
              m_match = 1'b1;
            end else begin
              m_match = 1'b0;
              if (m_err != 8'd255) m_err = m_err + 8'd1;
            end
          end
        end
        if (!m_busy && in_valid) begin
          m_active = 1'b1;
          m_d      = 0;
          m_data   = in_data;
        end
      end
    end
  end

  function automatic logic [15:0] exp_vec();
    logic       rdy, sb, en;
    logic [2:0] sel;
    rdy = 1'b1; sb = 1'b0; en = 1'b0; sel = 3'd0;
    if (m_active && m_d < 8) begin
      rdy = 1'b0; en = 1'b1; sb = tx_order(m_data, m_d);
    end else if (m_active) begin
      rdy = 1'b0; sel = 3'(m_d - 8);
    end
    return {rdy, sb, en, sel, m_done, m_match, m_err};
  endfunction

  // Every-cycle comparison of all outputs against the model.
  initial begin
    logic [15:0] act, exp;
    forever begin
      @(negedge clk);
      act = {in_ready, s, enable, a, b, c, done, match, err_cnt};
      exp = exp_vec();
      total++;
      if (act !== exp) begin
        bad++;
        if (bad <= 20) $display("FAIL outputs cyc=%0d act=%h exp=%h", cyc, act, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Offers d until accepted; returns accept cycle and cycles spent with in_ready low.
  task automatic send(input logic [7:0] d, input logic [7:0] m, input bit hold,
                      output int acc, output int waits);
    logic r;
    bit   got;
    in_data  = d;
    in_valid = 1'b1;
    waits    = 0;
    got      = 1'b0;
    acc      = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      r = in_ready;
      if (!r) waits++;
      @(posedge clk);
      if (r) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    if (got) begin
      flip_mask = m;
      acc = cyc;
      if (!hold) in_valid = 1'b0;
    end else begin
      in_valid = 1'b0;
      total++;
      bad++;
      $display("FAIL send_timeout act=no_accept exp=accept");
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [7:0] m,
                           output logic [7:0] sb, output int lat);
    int acc, w;
    send(d, m, 1'b0, acc, w);
    sb  = 8'h00;
    lat = -1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j < 8) sb = {sb[6:0], s};
      if (done) begin
        lat = j;
        break;
      end
    end
    if (lat < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout act=no_done exp=done");
    end
  endtask

  initial begin
    #1000000;
    bad++;
    $display("FAIL global_timeout act=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [7:0] sb;
    int lat, acc1, acc2, w1, w2, ndone;
    bit hold;
    logic [7:0] d, m;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_enable", enable, 0);
    chk("rst_s", s, 0);
    chk("rst_sel", {a, b, c}, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    chk("rst_err", err_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // A5: palindromic bit pattern, same serial order in both builds
    run_frame(8'hA5, 8'h00, sb, lat);
    chk("a5_sbits", sb, 8'hA5);
    chk("a5_latency", lat, 16);
    chk("a5_match", match, 1);
    chk("a5_err", err_cnt, 0);
    chk("a5_q", q_ds, 8'hA5);

    // 3C with downstream bit 2 corrupted during readback
    @(posedge clk); #1;
    run_frame(8'h3C, 8'h04, sb, lat);
    chk("3c_latency", lat, 16);
    chk("3c_match", match, 0);
    chk("3c_err", err_cnt, 1);

    // Back-to-back FF then 00
    @(posedge clk); #1;
    send(8'hFF, 8'h00, 1'b1, acc1, w1);
    send(8'h00, 8'h00, 1'b0, acc2, w2);
    chk("b2b_first_no_wait", w1, 0);
    chk("b2b_ready_low", w2, 16);
    chk("b2b_period", acc2 - acc1, 17);
    lat = -1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done) begin lat = j; break; end
    end
    chk("b2b_latency", lat, 16);
    chk("b2b_match", match, 1);
    chk("b2b_err", err_cnt, 1);

    // Randomized frames, random corruption, random gaps and back-to-back offers
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom_range(0, 255));
      m = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      hold = (i != 39) && ($urandom_range(0, 1) == 1);
      send(d, m, hold, acc1, w1);
      if (!hold) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done) break;
    end
    @(posedge clk); #1;

    // Saturation of the mismatch counter
    for (int i = 0; i < 255; i++) begin
      send(8'($urandom_range(0, 255)), 8'hFF, 1'b0, acc1, w1);
    end
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("sat_err", err_cnt, 255);
    @(posedge clk); #1;
    run_frame(8'h5A, 8'h10, sb, lat);
    chk("sat_match", match, 0);
    chk("sat_err_hold", err_cnt, 255);

    // Reset during SHIFT cycle 4 aborts the frame
    @(posedge clk); #1;
    send(8'h5A, 8'h00, 1'b0, acc1, w1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_enable", enable, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_err_reset", err_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_err_after", err_cnt, 0);
    @(posedge clk); #1;
    run_frame(8'h81, 8'h00, sb, lat);
    chk("81_latency", lat, 16);
    chk("81_match", match, 1);
    chk("81_err", err_cnt, 0);

    // Bit-order pin
    @(posedge clk); #1;
    run_frame(8'h01, 8'h00, sb, lat);
`ifdef SERIAL_LOOPBACK_LSB_FIRST_EN
    chk("01_sbits_lsb", sb, 8'h80);
    chk("01_q_lsb", q_ds, 8'h80);
`else
    chk("01_sbits_msb", sb, 8'h01);
    chk("01_q_msb", q_ds, 8'h01);
`endif
    chk("01_match", match, 1);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_loopback_feeder.md
SERIAL_LOOPBACK_FEEDER -- requirements
Module: serial_loopback_feeder

Interface
REQ-001 Parameter WIDTH, default 8, frame width in bits; SHALL equal the downstream shift-register depth.
REQ-002 Parameter SEL_W, default 3, select width; SHALL equal log2(WIDTH).
REQ-003 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, reset; SHALL be asynchronous and active-low.
REQ-005 Port in_valid, input, 1, source offers in_data.
REQ-006 Port in_data, input, WIDTH, byte to serialize.
REQ-007 Port in_ready, output, 1, block can accept a byte.
REQ-008 Port S, output, 1, serial bit to downstream shifter.
REQ-009 Port enable, output, 1, downstream shift enable.
REQ-010 Port A, B, C, output, 1 each, readback select; {A,B,C} SHALL form index, A the MSB.
REQ-011 Port Z, input, 1, downstream readback bit selected by {A,B,C}.
REQ-012 Port done, output, 1, one-cycle end-of-frame pulse.
REQ-013 Port match, output, 1, last frame read back correctly.
REQ-014 Port err_cnt, output, 8, count of mismatched frames.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, CHECK; every output SHALL be registered.
REQ-016 IDLE: in_ready=1, enable=0; in_valid&in_ready at edge k SHALL latch in_data and move to SHIFT.
REQ-017 SHIFT: enable=1 for exactly WIDTH cycles after edge k, S=in_data[7] first down to in_data[0]; downstream captures on edges k+1..k+8.
REQ-018 At edge k+8 SHALL enter CHECK with enable=0 and {A,B,C}=0.
REQ-019 CHECK: {A,B,C} SHALL step 0..7, one per cycle; Z SHALL be sampled at each following edge (k+9..k+16) and compared with latched bit [{A,B,C}].
REQ-020 At edge k+16 SHALL return to IDLE, pulse done=1 for one cycle, set match=AND of all 8 compares.
REQ-021 match SHALL hold until the next done; accept-to-done latency SHALL be 16 cycles; next accept possible on the done cycle (17-cycle frame period).
REQ-022 On mismatch err_cnt SHALL increment by 1 and saturate at 255, never wrap.
REQ-023 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE SHALL be ignored, no data lost (source holds per handshake).
REQ-024 enable SHALL never be 1 outside SHIFT, so the downstream register is frozen during CHECK.
REQ-025 {A,B,C} SHALL hold 0 in IDLE and SHIFT.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, in_ready=1 after release, S=0, enable=0, {A,B,C}=0, done=0, match=0, err_cnt=0.
REQ-027 Reset during SHIFT or CHECK SHALL abort the frame without done or err_cnt change; downstream contents are then undefined.

Configuration
REQ-028 Macro SERIAL_LOOPBACK_LSB_FIRST_EN defined: S SHALL send in_data[0] first; CHECK SHALL compare Z at index i with in_data[WIDTH-1-i].
REQ-029 Macro undefined: MSB-first order per REQ-017/REQ-019; latency identical in both builds.

Structure
REQ-030 Shared package ser_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, CHECK), WIDTH and SEL_W defaults, ERR_CNT_MAX=255.
REQ-031 Bit-index counter (load, step, terminal-count flag) SHALL be sub-module ser_bit_cnt, reused by SHIFT and CHECK.

Verification
REQ-032 Bench SHALL model downstream shifter (Q={Q[6:0],S} when enable; Z=Q[{A,B,C}]).
REQ-033 Accept 8'hA5 -> S sequence 1,0,1,0,0,1,0,1; done at 16 cycles; match=1; err_cnt=0.
REQ-034 Accept 8'h3C, force Q[2] inverted during CHECK -> match=0; err_cnt=1.
REQ-035 Back-to-back in_valid with 8'hFF then 8'h00 -> second accepted on first done cycle; both match=1; in_ready=0 for 16 cycles each.
REQ-036 Preset err_cnt to 255 via 255 mismatched frames, one more mismatch -> err_cnt stays 255.
REQ-037 rst_n low at SHIFT cycle 4 -> enable=0 immediately, no done, err_cnt unchanged; next 8'h81 frame -> match=1.
REQ-038 With SERIAL_LOOPBACK_LSB_FIRST_EN, accept 8'h01 -> S first bit=1; model Q=8'h80; match=1.
